uart_cmd_responder: RTL and testbench

- Command endpoint on the user side of the uart block: consumes received bytes (rx_valid/data) and drives transmit bytes (send_valid/tx_ready).
- Parses simple byte-framed read/write commands from a host, performs single-cycle register-bus accesses and returns a one-byte response.
- Sits between uart and the design's control/status register file.

---
 rtl/uart_cmd_responder.sv | 218 +++++++++++++++++++++
 tb/tb_uart_cmd_responder.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_responder.sv
`default_nettype none
// ============================================================================
// Module   : uart_cmd_responder
// Brief    : Byte-framed register read/write command endpoint behind a UART.
//            A write request is CMD_WRITE, addr, data and is answered with ACK (0x06).
//            A read request is CMD_READ, addr and is answered with the register value.
//            An error is answered with NAK (0x15).
//            Each error event adds one to err_count, which saturates at all-ones.
// Option   : UART_CMD_CHECKSUM_EN adds a trailing XOR checksum byte to each
//            request and a (response ^ opcode) byte after each response.
// Revision : 1.0 - initial release
// ============================================================================
module uart_cmd_responder #(
  parameter int                   WORD_SIZE      = 8,
  parameter int                   TIMEOUT_CYCLES = 4000,
  parameter logic [WORD_SIZE-1:0] CMD_WRITE      = 8'h57,
  parameter logic [WORD_SIZE-1:0] CMD_READ       = 8'h52
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 rx_valid,
  input  logic [WORD_SIZE-1:0] rx_data,
  input  logic                 tx_ready,
  output logic                 send_valid,
  output logic [WORD_SIZE-1:0] tx_data,
  output logic                 reg_wr_en,
  output logic [WORD_SIZE-1:0] reg_addr,
  output logic [WORD_SIZE-1:0] reg_wdata,
  input  logic [WORD_SIZE-1:0] reg_rdata,
  output logic                 busy,
  output logic [WORD_SIZE-1:0] err_count
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_GET_ADDR  = 3'd1;
  localparam logic [2:0] S_GET_DATA  = 3'd2;
  localparam logic [2:0] S_EXEC      = 3'd3;
  localparam logic [2:0] S_SEND_RESP = 3'd4;
  localparam logic [2:0] S_GET_CSUM  = 3'd5;
  localparam logic [2:0] S_SEND_CSUM = 3'd6;

  localparam logic [WORD_SIZE-1:0] ACK = WORD_SIZE'(8'h06);
  localparam logic [WORD_SIZE-1:0] NAK = WORD_SIZE'(8'h15);

  // Counter wide enough to hold TIMEOUT_CYCLES-1 for any legal parameter value.
  localparam int              TW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0]   TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [2:0]           state;
  logic [WORD_SIZE-1:0] opcode;
  logic [TW-1:0]        tmo_cnt;

  logic is_write;
  logic op_known;
  logic waiting;
  logic tmo_hit;
  logic accepted;
  logic overrun;
  logic bad_op;
  logic csum_bad;
  logic err_event;

`ifdef UART_CMD_CHECKSUM_EN
  logic [WORD_SIZE-1:0] csum_acc;     // running XOR of the request bytes
  logic                 single_resp;  // unknown-opcode NAK carries no check byte
`endif

  assign is_write = (opcode == CMD_WRITE);
  assign op_known = (rx_data == CMD_WRITE) || (rx_data == CMD_READ);
  assign accepted = send_valid && tx_ready;

`ifdef UART_CMD_CHECKSUM_EN
  assign waiting  = (state == S_GET_ADDR) || (state == S_GET_DATA) || (state == S_GET_CSUM);
  assign overrun  = rx_valid && ((state == S_EXEC) || (state == S_SEND_RESP) ||
                                 (state == S_SEND_CSUM));
  assign csum_bad = rx_valid && (state == S_GET_CSUM) && ((csum_acc ^ rx_data) != '0);
  assign send_valid = (state == S_SEND_RESP) || (state == S_SEND_CSUM);
`else
  assign waiting  = (state == S_GET_ADDR) || (state == S_GET_DATA);
  assign overrun  = rx_valid && ((state == S_EXEC) || (state == S_SEND_RESP));
  assign csum_bad = 1'b0;
  assign send_valid = (state == S_SEND_RESP);
`endif

  // A byte arriving in the expiry cycle wins over the timeout.
  assign tmo_hit   = waiting && !rx_valid && (tmo_cnt == TMO_LAST);
  assign bad_op    = rx_valid && (state == S_IDLE) && !op_known;
  // Simultaneous error sources still count as a single event.
  assign err_event = bad_op || tmo_hit || overrun || csum_bad;

  assign busy      = (state != S_IDLE);
  // EXEC is only reachable for a complete (and, if enabled, verified) request.
  assign reg_wr_en = (state == S_EXEC) && is_write;

  // Main request/response sequencer and its captured fields.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= S_IDLE;
      opcode    <= '0;
      reg_addr  <= '0;
      reg_wdata <= '0;
      tx_data   <= '0;
`ifdef UART_CMD_CHECKSUM_EN
      csum_acc    <= '0;
      single_resp <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (rx_valid) begin
            if (op_known) begin
              opcode <= rx_data;
              state  <= S_GET_ADDR;
`ifdef UART_CMD_CHECKSUM_EN
              csum_acc    <= rx_data;
              single_resp <= 1'b0;
`endif
            end else begin
              tx_data <= NAK;
              state   <= S_SEND_RESP;
`ifdef UART_CMD_CHECKSUM_EN
              single_resp <= 1'b1;
`endif
            end
          end
        end
        S_GET_ADDR: begin
          if (rx_valid) begin
            reg_addr <= rx_data;
`ifdef UART_CMD_CHECKSUM_EN
            csum_acc <= csum_acc ^ rx_data;
            state    <= is_write ? S_GET_DATA : S_GET_CSUM;
`else
            state    <= is_write ? S_GET_DATA : S_EXEC;
`endif
          end else if (tmo_hit) begin
            state <= S_IDLE;
          end
        end
        S_GET_DATA: begin
          if (rx_valid) begin
            reg_wdata <= rx_data;
`ifdef UART_CMD_CHECKSUM_EN
            csum_acc  <= csum_acc ^ rx_data;
            state     <= S_GET_CSUM;
`else
            state     <= S_EXEC;
`endif
          end else if (tmo_hit) begin
            state <= S_IDLE;
          end
        end
`ifdef UART_CMD_CHECKSUM_EN
        S_GET_CSUM: begin
          if (rx_valid) begin
            if (csum_bad) begin
              tx_data <= NAK;
              state   <= S_SEND_RESP;
            end else begin
              state   <= S_EXEC;
            end
          end else if (tmo_hit) begin
            state <= S_IDLE;
          end
        end
`endif
        S_EXEC: begin
          tx_data <= is_write ? ACK : reg_rdata;
          state   <= S_SEND_RESP;
        end
        S_SEND_RESP: begin
          if (accepted) begin
`ifdef UART_CMD_CHECKSUM_EN
            if (single_resp) begin
              state <= S_IDLE;
            end else begin
              tx_data <= tx_data ^ opcode;
              state   <= S_SEND_CSUM;
            end
`else
            state <= S_IDLE;
`endif
          end
        end
`ifdef UART_CMD_CHECKSUM_EN
        S_SEND_CSUM: begin
          if (accepted) begin
            state <= S_IDLE;
          end
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

  // Inter-byte timeout: runs only while waiting for request bytes.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tmo_cnt <= '0;
    end else if (rx_valid || !waiting) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  // Saturating error counter, at most one step per cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      err_count <= '0;
    end else if (err_event && (err_count != '1)) begin
      err_count <= err_count + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_cmd_responder
// Brief    : Directed self-checking bench for uart_cmd_responder with a small
//            register-file model (reset contents: regs[i] = i ^ 0x3B).
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_uart_cmd_responder;

  logic       clk;
  logic       rstn;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       tx_ready;
  logic       send_valid;
  logic [7:0] tx_data;
  logic       reg_wr_en;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic [7:0] reg_rdata;
  logic       busy;
  logic [7:0] err_count;

  logic [7:0] regs [0:255];
  int         wr_cnt;
  int         acc_cnt;
  int         n_checks;
  int         n_errors;
  int         acc_snap;
  int         bad;

`ifdef UART_CMD_CHECKSUM_EN
  localparam int RESP_BYTES = 2;
`else
  localparam int RESP_BYTES = 1;
`endif

  uart_cmd_responder dut (
    .clk        (clk),
    .rstn       (rstn),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .tx_ready   (tx_ready),
    .send_valid (send_valid),
    .tx_data    (tx_data),
    .reg_wr_en  (reg_wr_en),
    .reg_addr   (reg_addr),
    .reg_wdata  (reg_wdata),
    .reg_rdata  (reg_rdata),
    .busy       (busy),
    .err_count  (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign reg_rdata = regs[reg_addr];

  // Register file model and write-strobe counter.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < 256; i++) regs[i] <= 8'(i) ^ 8'h3B;
      wr_cnt <= 0;
    end else if (reg_wr_en) begin
      regs[reg_addr] <= reg_wdata;
      wr_cnt         <= wr_cnt + 1;
    end
  end

  // Count transmit handshakes.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) acc_cnt <= 0;
    else if (send_valid && tx_ready) acc_cnt <= acc_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_write(input logic [7:0] a, input logic [7:0] d);
    send_byte(8'h57);
    send_byte(a);
    send_byte(d);
`ifdef UART_CMD_CHECKSUM_EN
    send_byte(8'h57 ^ a ^ d);
`endif
  endtask

  task automatic send_read(input logic [7:0] a);
    send_byte(8'h52);
    send_byte(a);
`ifdef UART_CMD_CHECKSUM_EN
    send_byte(8'h52 ^ a);
`endif
  endtask

  // Called while the response is presented and tx_ready is high.
  task automatic finish_resp(input string tag, input logic [7:0] resp,
                             input logic [7:0] op, input bit two);
    check_eq({tag, "_sv"}, send_valid, 1'b1);
    check_eq({tag, "_tx"}, tx_data, resp);
    @(posedge clk); #1;
`ifdef UART_CMD_CHECKSUM_EN
    if (two) begin
      check_eq({tag, "_csv"}, send_valid, 1'b1);
      check_eq({tag, "_ctx"}, tx_data, resp ^ op);
      @(posedge clk); #1;
    end
`endif
    check_eq({tag, "_drop"}, send_valid, 1'b0);
    check_eq({tag, "_idle"}, busy, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    rstn     = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    tx_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_sv",    send_valid, 1'b0);
    check_eq("rst_tx",    tx_data,    8'h00);
    check_eq("rst_wr",    reg_wr_en,  1'b0);
    check_eq("rst_addr",  reg_addr,   8'h00);
    check_eq("rst_wdata", reg_wdata,  8'h00);
    check_eq("rst_busy",  busy,       1'b0);
    check_eq("rst_err",   err_count,  8'h00);
    rstn = 1'b1;

    // Write 0xA5 to 0x03: strobe one cycle after the last byte, ACK after that.
    send_write(8'h03, 8'hA5);
    check_eq("wr_en",    reg_wr_en,  1'b1);
    check_eq("wr_addr",  reg_addr,   8'h03);
    check_eq("wr_wdata", reg_wdata,  8'hA5);
    check_eq("wr_nosv",  send_valid, 1'b0);
    @(posedge clk); #1;
    check_eq("wr_en_drop", reg_wr_en, 1'b0);
    finish_resp("wr", 8'h06, 8'h57, 1'b1);
    check_eq("wr_count", wr_cnt,    1);
    check_eq("wr_err",   err_count, 8'h00);

    // Read 0x07 (reset contents 0x3C).
    send_read(8'h07);
    check_eq("rd_noen", reg_wr_en,  1'b0);
    check_eq("rd_busy", busy,       1'b1);
    check_eq("rd_nosv", send_valid, 1'b0);
    @(posedge clk); #1;
    finish_resp("rd", 8'h3C, 8'h52, 1'b1);
    check_eq("rd_wrcnt", wr_cnt, 1);

    // Read back the earlier write.
    send_read(8'h03);
    @(posedge clk); #1;
    finish_resp("rdback", 8'hA5, 8'h52, 1'b1);

    // Backpressure: 50 cycles of tx_ready low.
    tx_ready = 1'b0;
    acc_snap = acc_cnt;
    send_read(8'h07);
    @(posedge clk); #1;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      if (send_valid !== 1'b1 || tx_data !== 8'h3C) bad++;
      @(posedge clk); #1;
    end
    check_eq("bp_stable", bad, 0);
    check_eq("bp_noacc",  acc_cnt - acc_snap, 0);
    tx_ready = 1'b1;
    finish_resp("bp", 8'h3C, 8'h52, 1'b1);
    check_eq("bp_acc", acc_cnt - acc_snap, RESP_BYTES);

    // Unknown opcode: single-byte NAK.
    send_byte(8'h41);
    check_eq("nak_err", err_count, 8'h01);
    finish_resp("nak", 8'h15, 8'h41, 1'b0);

    // Timeout after 0x57,0x01: still waiting at 3999 cycles, idle at 4000.
    acc_snap = acc_cnt;
    send_byte(8'h57);
    send_byte(8'h01);
    repeat (3999) @(posedge clk);
    #1;
    check_eq("tmo_before", busy, 1'b1);
    @(posedge clk); #1;
    check_eq("tmo_idle",  busy,      1'b0);
    check_eq("tmo_err",   err_count, 8'h02);
    check_eq("tmo_nowr",  wr_cnt,    1);
    check_eq("tmo_notx",  acc_cnt - acc_snap, 0);

    // Overrun: byte injected while a response is stalled.
    tx_ready = 1'b0;
    send_read(8'h07);
    @(posedge clk); #1;
    send_byte(8'h99);
    check_eq("ovr_err", err_count,  8'h03);
    check_eq("ovr_sv",  send_valid, 1'b1);
    tx_ready = 1'b1;
    finish_resp("ovr", 8'h3C, 8'h52, 1'b1);

    // Saturation: 260 more unknown opcodes.
    for (int i = 0; i < 260; i++) send_byte(8'h41);
    @(posedge clk); #1;
    check_eq("sat_err",  err_count, 8'hFF);
    check_eq("sat_idle", busy,      1'b0);

    // Reset between address and data of a write.
    send_byte(8'h57);
    send_byte(8'h05);
    #2;
    rstn = 1'b0;
    #1;
    check_eq("mrst_busy",  busy,       1'b0);
    check_eq("mrst_err",   err_count,  8'h00);
    check_eq("mrst_addr",  reg_addr,   8'h00);
    check_eq("mrst_wdata", reg_wdata,  8'h00);
    check_eq("mrst_sv",    send_valid, 1'b0);
    check_eq("mrst_tx",    tx_data,    8'h00);
    check_eq("mrst_wr",    reg_wr_en,  1'b0);
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    send_write(8'h05, 8'h77);
    check_eq("post_en",    reg_wr_en, 1'b1);
    check_eq("post_addr",  reg_addr,  8'h05);
    check_eq("post_wdata", reg_wdata, 8'h77);
    @(posedge clk); #1;
    finish_resp("post", 8'h06, 8'h57, 1'b1);
    check_eq("post_wrcnt", wr_cnt,    1);
    check_eq("post_err",   err_count, 8'h00);
    send_read(8'h05);
    @(posedge clk); #1;
    finish_resp("post_rd", 8'h77, 8'h52, 1'b1);

`ifdef UART_CMD_CHECKSUM_EN
    // Explicit checksum frames: good (0xF1) and bad (0x00).
    send_byte(8'h57); send_byte(8'h03); send_byte(8'hA5); send_byte(8'hF1);
    check_eq("cs_en", reg_wr_en, 1'b1);
    @(posedge clk); #1;
    finish_resp("cs", 8'h06, 8'h57, 1'b1);
    send_byte(8'h57); send_byte(8'h03); send_byte(8'hA5); send_byte(8'h00);
    check_eq("csbad_en",  reg_wr_en, 1'b0);
    check_eq("csbad_err", err_count, 8'h01);
    finish_resp("csbad", 8'h15, 8'h57, 1'b1);
    check_eq("csbad_wrcnt", wr_cnt, 2);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
